// File: rtl/time_set_pkg.sv
// Shared types, field codes and BCD/calendar helpers for the time/date editor.
package time_set_pkg;

   typedef enum logic [2:0] {ST_IDLE, ST_F1, ST_F2, ST_F3, ST_COMMIT} state_t;

   localparam logic [1:0] FLD_NONE = 2'd0;
   localparam logic [1:0] FLD_1    = 2'd1;
   localparam logic [1:0] FLD_2    = 2'd2;
   localparam logic [1:0] FLD_3    = 2'd3;

   localparam int NUM_BTN = 3;
   localparam int BTN_CHG = 0;
   localparam int BTN_INC = 1;
   localparam int BTN_DEC = 2;

   localparam logic [23:0] TIME_RST = 24'h000000;
   localparam logic [31:0] DATE_RST = 32'h01012024;

   typedef struct packed {
      logic [7:0] hour;
      logic [7:0] min;
      logic [7:0] sec;
   } time_bcd_t;

   typedef struct packed {
      logic [7:0]  day;
      logic [7:0]  month;
      logic [15:0] year;
   } date_bcd_t;

   // Out-of-range values (above mx) wrap to mn like the top of the range does.
   function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] mn,
                                           input logic [7:0] mx);
      if (v >= mx) return mn;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd2_dec(input logic [7:0] v, input logic [7:0] mn,
                                           input logic [7:0] mx);
      if (v <= mn) return mx;
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   function automatic logic [15:0] year_inc(input logic [15:0] y);
      if (y[7:0] == 8'h99) return {bcd2_inc(y[15:8], 8'h00, 8'h99), 8'h00};
      return {y[15:8], bcd2_inc(y[7:0], 8'h00, 8'h99)};
   endfunction

   function automatic logic [15:0] year_dec(input logic [15:0] y);
      if (y[7:0] == 8'h00) return {bcd2_dec(y[15:8], 8'h00, 8'h99), 8'h99};
      return {y[15:8], bcd2_dec(y[7:0], 8'h00, 8'h99)};
   endfunction

   // 10*t + o is divisible by 4 exactly when 2*t + o is.
   function automatic logic bcd2_div4(input logic [7:0] v);
      return ((({v[7:4], 1'b0}) + {1'b0, v[3:0]}) & 5'd3) == 5'd0;
   endfunction

   function automatic logic is_leap(input logic [15:0] year_bcd);
      if (year_bcd[7:0] != 8'h00) return bcd2_div4(year_bcd[7:0]);
      return bcd2_div4(year_bcd[15:8]);
   endfunction

   function automatic logic [7:0] days_in_month(input logic [7:0] month_bcd,
                                                input logic [15:0] year_bcd);
      case (month_bcd)
         8'h02:                      return is_leap(year_bcd) ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one active-low pushbutton; emits a one-cycle press pulse.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int DEBOUNCE_W      = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press
);

   localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]            sync;
   logic                  lvl;
   logic [DEBOUNCE_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= 2'b11;
         lvl   <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn_n};
         press <= 1'b0;
         if (sync[1] == lvl) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // Only a released->pressed acceptance makes a pulse.
            cnt   <= '0;
            lvl   <= sync[1];
            press <= lvl;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/time_date_setter.sv
// Pushbutton editor for the clock/calendar: edits a BCD shadow copy and strobes it back on commit.
module time_date_setter
   import time_set_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int DEBOUNCE_W      = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sw_mode,
   input  logic        butt_change,
   input  logic        butt_increase,
   input  logic        butt_decrease,
   input  logic [23:0] cur_time,
   input  logic [31:0] cur_date,
   output logic [23:0] set_time,
   output logic [31:0] set_date,
   output logic        load_time,
   output logic        load_date,
   output logic        edit_active,
   output logic [1:0]  edit_field
);

   logic [NUM_BTN-1:0] btn_n, press;
   assign btn_n = {butt_decrease, butt_increase, butt_change};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .DEBOUNCE_W      (DEBOUNCE_W)
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .btn_n (btn_n[i]),
         .press (press[i])
      );
   end

   logic chg, adj_up, adj_dn;
   assign chg    = press[BTN_CHG];
   assign adj_up = press[BTN_INC] & ~press[BTN_DEC] & ~chg;
   assign adj_dn = press[BTN_DEC] & ~press[BTN_INC] & ~chg;

   state_t    state, state_nxt;
   logic      edit_kind;
   time_bcd_t sh_time;
   date_bcd_t sh_date;
   logic      mode_ok, in_field;
   logic [7:0] dim_sh, day_clamped;

   assign mode_ok     = (sw_mode == edit_kind);
   assign in_field    = (state == ST_F1) || (state == ST_F2) || (state == ST_F3);
   assign dim_sh      = days_in_month(sh_date.month, sh_date.year);
   assign day_clamped = (sh_date.day > dim_sh) ? dim_sh : sh_date.day;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (chg) state_nxt = ST_F1;
         ST_F1:     if (!mode_ok) state_nxt = ST_IDLE; else if (chg) state_nxt = ST_F2;
         ST_F2:     if (!mode_ok) state_nxt = ST_IDLE; else if (chg) state_nxt = ST_F3;
         ST_F3:     if (!mode_ok) state_nxt = ST_IDLE; else if (chg) state_nxt = ST_COMMIT;
         ST_COMMIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      edit_active = (state != ST_IDLE);
      load_time   = (state == ST_COMMIT) && !edit_kind;
      load_date   = (state == ST_COMMIT) &&  edit_kind;
      case (state)
         ST_F1:   edit_field = FLD_1;
         ST_F2:   edit_field = FLD_2;
         ST_F3:   edit_field = FLD_3;
         default: edit_field = FLD_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         edit_kind <= 1'b0;
         sh_time   <= TIME_RST;
         sh_date   <= DATE_RST;
      end else if (state == ST_IDLE && chg) begin
         edit_kind <= sw_mode;
         sh_time   <= cur_time;
         sh_date   <= cur_date;
      end else if (in_field && mode_ok && (adj_up || adj_dn)) begin
         case (state)
            ST_F1:
               if (edit_kind)
                  sh_date.day  <= adj_up ? bcd2_inc(sh_date.day, 8'h01, dim_sh)
                                         : bcd2_dec(sh_date.day, 8'h01, dim_sh);
               else
                  sh_time.hour <= adj_up ? bcd2_inc(sh_time.hour, 8'h00, 8'h23)
                                         : bcd2_dec(sh_time.hour, 8'h00, 8'h23);
            ST_F2:
               if (edit_kind)
                  sh_date.month <= adj_up ? bcd2_inc(sh_date.month, 8'h01, 8'h12)
                                          : bcd2_dec(sh_date.month, 8'h01, 8'h12);
               else
                  sh_time.min   <= adj_up ? bcd2_inc(sh_time.min, 8'h00, 8'h59)
                                          : bcd2_dec(sh_time.min, 8'h00, 8'h59);
            ST_F3:
               if (edit_kind)
                  sh_date.year <= adj_up ? year_inc(sh_date.year) : year_dec(sh_date.year);
               else
                  sh_time.sec  <= adj_up ? bcd2_inc(sh_time.sec, 8'h00, 8'h59)
                                         : bcd2_dec(sh_time.sec, 8'h00, 8'h59);
            default: ;
         endcase
      end
   end

   // Outputs are registered on the way into COMMIT so they are valid with the strobe and hold after.
   always_ff @(posedge clk) begin
      if (rst) begin
         set_time <= TIME_RST;
         set_date <= DATE_RST;
      end else if (state_nxt == ST_COMMIT) begin
         if (edit_kind) set_date <= {day_clamped, sh_date.month, sh_date.year};
         else           set_time <= sh_time;
      end
   end

endmodule

// File: tb/tb_time_date_setter.sv
// Bench for time_date_setter: directed vector table plus random button sequences vs a calendar model.
module tb_time_date_setter;

   localparam int OP_END = 0, OP_CHG = 1, OP_INC = 2, OP_DEC = 3, OP_INCDEC = 4,
                  OP_CHGINC = 5, OP_TOG = 6, OP_RST = 7;

   logic        clk = 1'b0, rst = 1'b1, sw_mode = 1'b0;
   logic        bc = 1'b1, bi = 1'b1, bd = 1'b1;
   logic [23:0] cur_time = 24'h0;
   logic [31:0] cur_date = 32'h01012024;
   logic [23:0] set_time;
   logic [31:0] set_date;
   logic        load_time, load_date, edit_active;
   logic [1:0]  edit_field;

   always #5 clk = ~clk;

   time_date_setter #(.DEBOUNCE_CYCLES(4), .DEBOUNCE_W(3)) dut (
      .clk(clk), .rst(rst), .sw_mode(sw_mode),
      .butt_change(bc), .butt_increase(bi), .butt_decrease(bd),
      .cur_time(cur_time), .cur_date(cur_date),
      .set_time(set_time), .set_date(set_date),
      .load_time(load_time), .load_date(load_date),
      .edit_active(edit_active), .edit_field(edit_field)
   );

   int n_vec = 0, n_err = 0;
   int n_lt = 0, n_ld = 0;

   always @(negedge clk) begin
      if (load_time) n_lt++;
      if (load_date) n_ld++;
      if (load_time && load_date) begin
         n_err++;
         $display("FAIL both_strobes: load_time=1 load_date=1, required at most one");
      end
   end

   // Reference model: plain integers, calendar arithmetic.
   int   m_h, m_m, m_s, m_d, m_mo, m_y, m_fld, m_nt = 0, m_nd = 0;
   bit   m_kind;
   logic [23:0] m_set_t = 24'h0;
   logic [31:0] m_set_d = 32'h01012024;

   function automatic int b2i(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] i2b(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic int dim(input int mo, input int y);
      bit leap;
      leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
      if (mo == 2) return leap ? 29 : 28;
      if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
      return 31;
   endfunction

   task automatic m_change();
      if (m_fld == 0) begin
         m_kind = sw_mode;
         m_h = b2i(cur_time[23:16]); m_m = b2i(cur_time[15:8]); m_s = b2i(cur_time[7:0]);
         m_d = b2i(cur_date[31:24]); m_mo = b2i(cur_date[23:16]);
         m_y = b2i(cur_date[15:8]) * 100 + b2i(cur_date[7:0]);
         m_fld = 1;
      end else if (m_fld < 3) begin
         m_fld++;
      end else begin
         m_fld = 0;
         if (!m_kind) begin
            m_set_t = {i2b(m_h), i2b(m_m), i2b(m_s)};
            m_nt++;
         end else begin
            int d;
            d = (m_d > dim(m_mo, m_y)) ? dim(m_mo, m_y) : m_d;
            m_set_d = {i2b(d), i2b(m_mo), i2b(m_y / 100), i2b(m_y % 100)};
            m_nd++;
         end
      end
   endtask

   task automatic m_adjust(input int dir);
      int mx;
      if (m_fld == 0) return;
      if (!m_kind) begin
         case (m_fld)
            1: m_h = (m_h + 24 + dir) % 24;
            2: m_m = (m_m + 60 + dir) % 60;
            default: m_s = (m_s + 60 + dir) % 60;
         endcase
      end else begin
         case (m_fld)
            1: begin
               mx = dim(m_mo, m_y);
               if (dir > 0) m_d = (m_d >= mx) ? 1 : m_d + 1;
               else         m_d = (m_d <= 1) ? mx : m_d - 1;
            end
            2: m_mo = (m_mo - 1 + 12 + dir) % 12 + 1;
            default: m_y = (m_y + 10000 + dir) % 10000;
         endcase
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] mask);
      @(negedge clk);
      bc = ~mask[0]; bi = ~mask[1]; bd = ~mask[2];
      repeat (10) @(negedge clk);
      bc = 1'b1; bi = 1'b1; bd = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic do_op(input int op);
      case (op)
         OP_CHG:    push(3'b001);
         OP_INC:    push(3'b010);
         OP_DEC:    push(3'b100);
         OP_INCDEC: push(3'b110);
         OP_CHGINC: push(3'b011);
         OP_TOG: begin
            @(negedge clk);
            sw_mode = ~sw_mode;
            repeat (3) @(negedge clk);
         end
         OP_RST: begin
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            @(negedge clk);
         end
         default: ;
      endcase
      case (op)
         OP_CHG, OP_CHGINC: m_change();
         OP_INC:            m_adjust(1);
         OP_DEC:            m_adjust(-1);
         OP_TOG:            m_fld = 0;
         OP_RST: begin
            m_fld = 0; m_set_t = 24'h0; m_set_d = 32'h01012024;
         end
         default: ;
      endcase
      chk("edit_active", {31'b0, edit_active}, {31'b0, m_fld != 0});
      chk("edit_field", {30'b0, edit_field}, 32'(m_fld));
      chk("set_time", {8'b0, set_time}, {8'b0, m_set_t});
      chk("set_date", set_date, m_set_d);
      chk("load_time_count", 32'(n_lt), 32'(m_nt));
      chk("load_date_count", 32'(n_ld), 32'(m_nd));
   endtask

   typedef struct packed {
      logic        mode;
      logic [23:0] t;
      logic [31:0] d;
      logic [31:0] ops;   // op codes, first op in the top nibble, 0 terminates
      logic [23:0] et;
      logic [31:0] ed;
      logic [3:0]  ent;
      logic [3:0]  edn;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int lt0, ld0, op;
      logic [31:0] w;

      tbl[0]  = '{1'b0, 24'h235958, 32'h01012024, 32'h1211_1000, 24'h005958, 32'h01012024, 4'd1, 4'd0};
      tbl[1]  = '{1'b1, 24'h000000, 32'h31012023, 32'h1121_1000, 24'h000000, 32'h28022023, 4'd0, 4'd1};
      tbl[2]  = '{1'b1, 24'h000000, 32'h31012024, 32'h1121_1000, 24'h000000, 32'h29022024, 4'd0, 4'd1};
      tbl[3]  = '{1'b1, 24'h000000, 32'h15060000, 32'h1113_1000, 24'h000000, 32'h15069999, 4'd0, 4'd1};
      tbl[4]  = '{1'b1, 24'h000000, 32'h29031900, 32'h1131_1000, 24'h000000, 32'h28021900, 4'd0, 4'd1};
      tbl[5]  = '{1'b1, 24'h000000, 32'h29032000, 32'h1131_1000, 24'h000000, 32'h29022000, 4'd0, 4'd1};
      tbl[6]  = '{1'b0, 24'h123456, 32'h01012024, 32'h1141_1000, 24'h123456, 32'h01012024, 4'd1, 4'd0};
      tbl[7]  = '{1'b0, 24'h123456, 32'h01012024, 32'h1521_1000, 24'h123556, 32'h01012024, 4'd1, 4'd0};
      tbl[8]  = '{1'b0, 24'h123456, 32'h01012024, 32'h1160_0000, 24'h000000, 32'h01012024, 4'd0, 4'd0};
      tbl[9]  = '{1'b0, 24'h123456, 32'h01012024, 32'h1117_0000, 24'h000000, 32'h01012024, 4'd0, 4'd0};
      tbl[10] = '{1'b0, 24'h000000, 32'h01012024, 32'h1313_1310, 24'h235959, 32'h01012024, 4'd1, 4'd0};
      tbl[11] = '{1'b1, 24'h000000, 32'h01042023, 32'h1311_1000, 24'h000000, 32'h30042023, 4'd0, 4'd1};

      m_fld = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_edit_active", {31'b0, edit_active}, 32'd0);
      chk("reset_edit_field", {30'b0, edit_field}, 32'd0);
      chk("reset_set_time", {8'b0, set_time}, 32'h0);
      chk("reset_set_date", set_date, 32'h01012024);

      // A 3-cycle glitch is one cycle short of the debounce window.
      bc = 1'b0;
      repeat (3) @(negedge clk);
      bc = 1'b1;
      repeat (12) @(negedge clk);
      chk("glitch_edit_active", {31'b0, edit_active}, 32'd0);
      chk("glitch_edit_field", {30'b0, edit_field}, 32'd0);
      chk("glitch_strobes", 32'(n_lt + n_ld), 32'd0);

      for (int v = 0; v < 12; v++) begin
         do_op(OP_RST);
         sw_mode  = tbl[v].mode;
         cur_time = tbl[v].t;
         cur_date = tbl[v].d;
         lt0 = n_lt; ld0 = n_ld;
         w = tbl[v].ops;
         for (int i = 0; i < 8; i++) begin
            op = int'(w[31-4*i -: 4]);
            if (op == OP_END) break;
            do_op(op);
         end
         chk($sformatf("vec%0d_set_time", v), {8'b0, set_time}, {8'b0, tbl[v].et});
         chk($sformatf("vec%0d_set_date", v), set_date, tbl[v].ed);
         chk($sformatf("vec%0d_n_load_time", v), 32'(n_lt - lt0), 32'(tbl[v].ent));
         chk($sformatf("vec%0d_n_load_date", v), 32'(n_ld - ld0), 32'(tbl[v].edn));
      end

      for (int s = 0; s < 40; s++) begin
         int y, mo, d, r, years[6];
         years = '{0, 1900, 2000, 2023, 2024, 9999};
         y  = ($urandom_range(0, 1) == 0) ? years[$urandom_range(0, 5)] : int'($urandom_range(0, 9999));
         mo = int'($urandom_range(1, 12));
         d  = int'($urandom_range(1, dim(mo, y)));
         cur_date = {i2b(d), i2b(mo), i2b(y / 100), i2b(y % 100)};
         cur_time = {i2b(int'($urandom_range(0, 23))), i2b(int'($urandom_range(0, 59))),
                     i2b(int'($urandom_range(0, 59)))};
         if (m_fld == 0) sw_mode = 1'($urandom_range(0, 1));
         for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(0, 99));
            if      (r < 30) op = OP_CHG;
            else if (r < 55) op = OP_INC;
            else if (r < 80) op = OP_DEC;
            else if (r < 85) op = OP_INCDEC;
            else if (r < 90) op = OP_CHGINC;
            else if (r < 95) op = OP_TOG;
            else             op = OP_RST;
            do_op(op);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
